// File: rtl/issue_scoreboard_if.sv
// Decode-side handshake and writeback bundle for the issue scoreboard.
//   master : decode / IF-ID side; offers instructions, drives ID/EX ready and writebacks
//   slave  : scoreboard; returns in_ready / out_valid
// Signals: in_valid/in_ready, inst, rs1_used, rs2_used, rd_write, flush,
//          out_valid/out_ready, wb_valid, wb_addr
interface issue_scoreboard_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        rs1_used;
  logic        rs2_used;
  logic        rd_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  modport master (
    output in_valid, inst, rs1_used, rs2_used, rd_write, flush, out_ready,
           wb_valid, wb_addr,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, inst, rs1_used, rs2_used, rd_write, flush, out_ready,
           wb_valid, wb_addr,
    output in_ready, out_valid
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue gate between IF/ID and ID/EX.
// Keeps a pending-write counter per architectural register (x0 has none),
// stalls decode on RAW hazards or a saturated WAW counter, and retires
// pending writes on writeback.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : issue handshake + writeback (issue_scoreboard_if.slave)
//   busy_mask    : bit r set while register r has writes in flight
//   stall_cycles : saturating count of hazard-stall cycles
//   wb_err       : sticky, writeback seen for a register with no pending write
module issue_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  issue_scoreboard_if.slave bus,
  output logic [NREG-1:0]   busy_mask,
  output logic [31:0]       stall_cycles,
  output logic              wb_err
);
  localparam int unsigned AW = 5;
  localparam int unsigned SW = 32;

  logic [NREG-1:1][CNT_W-1:0] cnt;
  logic [NREG-1:1][CNT_W-1:0] cnt_nxt;
  logic [NREG-1:1]            inc_vec;
  logic [NREG-1:1]            dec_vec;

  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [AW-1:0]    rd;
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_wb;
  logic             raw_hz;
  logic             waw_sat;
  logic             hazard;
  logic             fire;
  logic             wb_miss;
  logic             stall_en;
  logic             unused_inst_bits;

  // Pending count lookup; x0 and out-of-range addresses read as zero.
  function automatic logic [CNT_W-1:0] cnt_of(
    input logic [NREG-1:1][CNT_W-1:0] c,
    input logic [AW-1:0]              a
  );
    cnt_of = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (a == AW'(r)) cnt_of = c[r];
    end
  endfunction

  assign rs1 = bus.inst[19:15];
  assign rs2 = bus.inst[24:20];
  assign rd  = bus.inst[11:7];
  assign unused_inst_bits = ^{bus.inst[31:25], bus.inst[14:12], bus.inst[6:0]};

  assign cnt_rs1 = cnt_of(cnt, rs1);
  assign cnt_rs2 = cnt_of(cnt, rs2);
  assign cnt_rd  = cnt_of(cnt, rd);
  assign cnt_wb  = cnt_of(cnt, bus.wb_addr);

  // Hazards use registered counts only; a writeback this cycle does not bypass.
  assign raw_hz  = (bus.rs1_used && (rs1 != '0) && (cnt_rs1 != '0)) ||
                   (bus.rs2_used && (rs2 != '0) && (cnt_rs2 != '0));
  assign waw_sat = bus.rd_write && (rd != '0) && (cnt_rd == '1);
  assign hazard  = raw_hz || waw_sat;

  // A flushed instruction is consumed (in_ready) but never issued.
  assign bus.out_valid = bus.in_valid && !hazard && !bus.flush;
  assign bus.in_ready  = (bus.out_ready && !hazard) || bus.flush;
  assign fire          = bus.out_valid && bus.out_ready;

  assign wb_miss  = bus.wb_valid && (bus.wb_addr != '0) && (cnt_wb == '0);
  assign stall_en = bus.in_valid && !bus.flush && hazard;

  // Per-register issue / retire strobes.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc_vec[r] = fire && bus.rd_write && (rd == AW'(r));
      dec_vec[r] = bus.wb_valid && (bus.wb_addr == AW'(r)) && (cnt[r] != '0);
    end
  end

  // Next counts; simultaneous issue and retire cancel out.
  always_comb begin
    cnt_nxt = cnt;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_nxt[r] = cnt[r] + CNT_W'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        cnt_nxt[r] = cnt[r] - CNT_W'(1);
      end
    end
  end

  // Busy view of the counters; x0 is never busy.
  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      busy_mask[r] = (cnt[r] != '0);
    end
  end

  // Counter, statistics and error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      stall_cycles <= '0;
      wb_err       <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (wb_miss) wb_err <= 1'b1;
      if (stall_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + SW'(1);
    end
  end
endmodule
